// File: rtl/acc_hash_sched.sv
// acc_hash_sched: round-robin issue of NREQ requesters into one shared
// fixed-latency hash pipeline. Tags ride a valid/tag shift register alongside
// the pipeline and are rejoined with the hash at the tail into a result FIFO.
// The inflight credit count (pipeline + FIFO) never exceeds FIFO_DEPTH, so
// every issued request is guaranteed a FIFO slot on arrival.
module acc_hash_sched #(
  parameter int NREQ       = 4,
  parameter int DATA_W     = 64,
  parameter int NBITS      = 15,
  parameter int LATENCY    = 6,
  parameter int FIFO_DEPTH = 8,
  localparam int TAG_W     = $clog2(NREQ),
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_enable,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  input  logic [NREQ-1:0]          req_sign,
  output logic                     pipe_valid,
  output logic [DATA_W-1:0]        pipe_data,
  output logic                     pipe_sign,
  input  logic [NBITS-1:0]         pipe_hash,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [TAG_W-1:0]         res_tag,
  output logic [NBITS-1:0]         res_hash,
  output logic [CNT_W-1:0]         inflight
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [NBITS-1:0] hash;
  } res_t;

  // Flat payload bus viewed as one packed entry per requester.
  logic [NREQ-1:0][DATA_W-1:0] data_a;
  assign data_a = req_data;

  logic [TAG_W-1:0] rr_ptr, gnt, pipe_tag;
  logic             issue, pop, push, full;
  logic [CNT_W-1:0] infl_eff, count;
  logic [PTR_W-1:0] wptr, rptr;
  res_t             mem [FIFO_DEPTH];

  // Valid/tag shadow of the hash pipeline; stage LATENCY lines up with pipe_hash.
  logic [LATENCY:1]            vld_pipe;
  logic [LATENCY:1][TAG_W-1:0] tag_pipe;

  // Round-robin search starting at rr_ptr, wrapping modulo NREQ.
  always_comb begin : arb
    int               idx;
    logic             found;
    logic [TAG_W-1:0] cand;
    idx   = 0;
    found = 1'b0;
    cand  = '0;
    gnt   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = TAG_W'(idx);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
  end

  // Credit check uses the post-pop count so a pop frees a slot for same-cycle issue.
  always_comb begin
    pop       = res_valid && res_ready;
    infl_eff  = inflight - CNT_W'(pop);
    issue     = cfg_enable && (infl_eff < CNT_W'(FIFO_DEPTH)) && (|req_valid);
    req_ready = issue ? (NREQ'(1) << gnt) : '0;
    push      = vld_pipe[LATENCY];
    full      = (count == CNT_W'(FIFO_DEPTH));
    res_valid = (count != '0);
    res_tag   = mem[rptr].tag;
    res_hash  = mem[rptr].hash;
  end

  // Arbiter pointer, registered pipeline issue, and the tag shadow pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      pipe_valid <= 1'b0;
      pipe_data  <= '0;
      pipe_sign  <= 1'b0;
      pipe_tag   <= '0;
      vld_pipe   <= '0;
      tag_pipe   <= '0;
    end else begin
      pipe_valid <= issue;
      if (issue) begin
        rr_ptr    <= (gnt == TAG_W'(NREQ - 1)) ? '0 : gnt + 1'b1;
        pipe_data <= data_a[gnt];
        pipe_sign <= req_sign[gnt];
        pipe_tag  <= gnt;
      end
      vld_pipe[1] <= pipe_valid;
      tag_pipe[1] <= pipe_tag;
      for (int k = 2; k <= LATENCY; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        tag_pipe[k] <= tag_pipe[k-1];
      end
    end
  end

  // FIFO pointers, occupancy and credit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      inflight <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count    <= count + CNT_W'(push) - CNT_W'(pop);
      inflight <= inflight + CNT_W'(issue) - CNT_W'(pop);
    end
  end

  // FIFO storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{tag: tag_pipe[LATENCY], hash: pipe_hash};
  end

  // Credit accounting must make an overflowing push impossible.
  always @(posedge clk) begin
    if (rst_n) assert (!(push && full));
  end

endmodule

// File: tb/tb_acc_hash_sched.sv
// Directed bench for acc_hash_sched with a behavioural hash pipeline and a
// scoreboard queue of expected {tag, hash} drained by an independent monitor.
module tb_acc_hash_sched;
  localparam int NREQ = 4, DATA_W = 64, NBITS = 15, LATENCY = 6, FIFO_DEPTH = 8;
  localparam int TAG_W = 2, CNT_W = 4;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   cfg_enable = 1'b0;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_sign;
  logic                   pipe_valid;
  logic [DATA_W-1:0]      pipe_data;
  logic                   pipe_sign;
  logic [NBITS-1:0]       pipe_hash;
  logic                   res_valid;
  logic                   res_ready = 1'b0;
  logic [TAG_W-1:0]       res_tag;
  logic [NBITS-1:0]       res_hash;
  logic [CNT_W-1:0]       inflight;

  acc_hash_sched #(.NREQ(NREQ), .DATA_W(DATA_W), .NBITS(NBITS), .LATENCY(LATENCY),
                   .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .req_valid(req_valid),
    .req_ready(req_ready), .req_data(req_data), .req_sign(req_sign),
    .pipe_valid(pipe_valid), .pipe_data(pipe_data), .pipe_sign(pipe_sign),
    .pipe_hash(pipe_hash), .res_valid(res_valid), .res_ready(res_ready),
    .res_tag(res_tag), .res_hash(res_hash), .inflight(inflight));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [NBITS-1:0] h;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  logic [DATA_W-1:0] dv [NREQ];
  initial begin
    dv[0] = 64'hDEAD_BEEF_0123_4567;
    dv[1] = 64'h0F0F_F0F0_AAAA_5555;
    dv[2] = 64'h0000_0000_0000_0001;
    dv[3] = 64'h8000_0000_0000_0001;
  end
  assign req_data = {dv[3], dv[2], dv[1], dv[0]};
  assign req_sign = 4'b1010;

  function automatic logic [NBITS-1:0] hf(input logic [DATA_W-1:0] d, input logic s);
    logic [NBITS-1:0] x;
    x = d[14:0] ^ d[29:15] ^ d[44:30] ^ d[59:45] ^ {11'b0, d[63:60]};
    return s ? ~x : x;
  endfunction

  function automatic exp_t expd(input int i);
    exp_t e;
    e.tag = TAG_W'(i);
    e.h   = hf(dv[i], req_sign[i]);
    return e;
  endfunction

  // Behavioural hash pipeline: no reset, fixed LATENCY.
  logic [NBITS-1:0] hq [LATENCY];
  always @(posedge clk) begin
    hq[0] <= hf(pipe_data, pipe_sign);
    for (int k = 1; k < LATENCY; k++) hq[k] <= hq[k-1];
  end
  assign pipe_hash = hq[LATENCY-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare every popped result against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop: got tag=%0d hash=%h want none", res_tag, res_hash);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("res_tag", 64'(res_tag), 64'(e.tag));
        chk("res_hash", 64'(res_hash), 64'(e.h));
      end
    end
  end

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drain(input string nm);
    for (int c = 0; c < 60; c++) begin
      nx();
      smp();
      if (inflight == '0 && !res_valid) break;
    end
    chk(nm, 64'(inflight), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int xfers;
    // Reset state
    #3;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_pipe_valid", 64'(pipe_valid), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_inflight", 64'(inflight), 64'd0);
    nx(); nx();
    rst_n = 1'b1;
    cfg_enable = 1'b1;
    res_ready = 1'b1;

    // Single request from requester 2, data=1 sign=0 -> hash 1
    nx();
    req_valid = 4'b0100;
    smp();
    chk("single_ready", 64'(req_ready), 64'h4);
    q.push_back('{tag: 2'd2, h: 15'h0001});
    nx();
    req_valid = 4'b0000;
    smp();
    chk("single_pipe_valid", 64'(pipe_valid), 64'd1);
    chk("single_pipe_data", pipe_data, 64'h1);
    for (int c = 2; c <= 7; c++) begin
      nx();
      smp();
      chk("single_early_res", 64'(res_valid), 64'd0);
    end
    nx();
    smp();
    chk("single_res_valid_c8", 64'(res_valid), 64'd1);
    drain("single_drain");

    // Wrap/skip: rr_ptr is 3, only 0 and 1 requesting
    nx();
    req_valid = 4'b0011;
    smp();
    chk("wrap_first", 64'(req_ready), 64'h1);
    q.push_back(expd(0));
    nx();
    smp();
    chk("wrap_second", 64'(req_ready), 64'h2);
    q.push_back(expd(1));
    nx();
    req_valid = 4'b0000;
    drain("wrap_drain");

    // Fresh reset so fairness starts from rr_ptr=0
    rst_n = 1'b0;
    nx();
    rst_n = 1'b1;

    // Fairness: all valid for 8 cycles
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      smp();
      chk("fair_grant", 64'(req_ready), 64'(1 << (k % 4)));
      q.push_back(expd(k % 4));
      nx();
    end
    req_valid = 4'b0000;
    smp();
    chk("fair_inflight_peak", 64'(inflight), 64'd8);
    drain("fair_drain");

    // Backpressure: consumer stalled, credit limit reached
    nx();
    res_ready = 1'b0;
    req_valid = 4'b1111;
    xfers = 0;
    for (int c = 0; c < 20; c++) begin
      smp();
      if (req_ready != '0) begin
        chk("bp_grant", 64'(req_ready), 64'(1 << (xfers % 4)));
        q.push_back(expd(xfers % 4));
        xfers++;
      end
      nx();
    end
    chk("bp_xfers", 64'(xfers), 64'd8);
    smp();
    chk("bp_ready_blocked", 64'(req_ready), 64'd0);
    chk("bp_inflight_full", 64'(inflight), 64'd8);
    nx();
    res_ready = 1'b1;
    smp();
    chk("bp_same_cycle_xfer", 64'(req_ready), 64'h1);
    q.push_back(expd(0));
    nx();
    res_ready = 1'b0;
    smp();
    chk("bp_ready_after_one", 64'(req_ready), 64'd0);
    chk("bp_inflight_held", 64'(inflight), 64'd8);
    nx();
    req_valid = 4'b0000;
    res_ready = 1'b1;
    drain("bp_drain");

    // cfg_enable dropped after 3 issues (rr_ptr now 1)
    nx();
    req_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("cfg_grant", 64'(req_ready), 64'(1 << (k + 1)));
      q.push_back(expd(k + 1));
      nx();
    end
    cfg_enable = 1'b0;
    for (int c = 0; c < 12; c++) begin
      smp();
      chk("cfg_hold", 64'(req_ready), 64'd0);
      nx();
    end
    req_valid = 4'b0000;
    drain("cfg_drain");

    // Async reset with 5 requests in flight
    cfg_enable = 1'b1;
    res_ready = 1'b0;
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) nx();
    req_valid = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pipe_valid", 64'(pipe_valid), 64'd0);
    chk("arst_res_valid", 64'(res_valid), 64'd0);
    chk("arst_inflight", 64'(inflight), 64'd0);
    chk("arst_req_ready", 64'(req_ready), 64'd0);
    nx(); nx();
    rst_n = 1'b1;
    res_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      smp();
      chk("arst_no_result", 64'(res_valid), 64'd0);
      nx();
    end
    chk("sb_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
